// File: rtl/ro_puf_eval.sv
`default_nettype none
// ============================================================================
// Module   : ro_puf_eval
// Purpose  : Ring-oscillator PUF evaluator. For each response bit a
//            challenge-derived oscillator pair is enabled. Both pairs'
//            synchronised rising edges are counted over a programmable
//            window, and the two counts are compared to produce one bit.
//            A start/busy/done handshake sequences the whole evaluation.
// Ports    : clk        - system clock
//            rst_n      - asynchronous reset, active HIGH (legacy name)
//            start      - evaluation request, sampled only while idle
//            challenge  - base oscillator index, captured at start
//            win_len    - count window in clk cycles (0 behaves as 1)
//            ro_in      - raw oscillator outputs, asynchronous to clk
//            ro_en      - oscillator enables (active pair only)
//            busy       - evaluation in progress
//            done       - one-cycle pulse when the response is final
//            response   - response register
//            tie        - sticky flag, set when any compare saw equal counts
// Options  : PUF_MAJORITY_EN - when defined, each bit is measured three
//            times on the same pair and resolved by a 2-of-3 vote.
// Revision : 1.0 - initial release
// ============================================================================
module ro_puf_eval #(
    parameter int NUM_RO    = 16,
    parameter int SEL_W     = $clog2(NUM_RO),
    parameter int CNT_W     = 16,
    parameter int WIN_W     = 16,
    parameter int RESP_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [SEL_W-1:0]     challenge,
    input  logic [WIN_W-1:0]     win_len,
    input  logic [NUM_RO-1:0]    ro_in,
    output logic [NUM_RO-1:0]    ro_en,
    output logic                 busy,
    output logic                 done,
    output logic [RESP_BITS-1:0] response,
    output logic                 tie
);

    localparam int IDX_W = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;

    localparam logic [2:0] c_ST_IDLE    = 3'd0;
    localparam logic [2:0] c_ST_ARM     = 3'd1;
    localparam logic [2:0] c_ST_COUNT   = 3'd2;
    localparam logic [2:0] c_ST_DRAIN   = 3'd3;
    localparam logic [2:0] c_ST_COMPARE = 3'd4;
    localparam logic [2:0] c_ST_FINISH  = 3'd5;

    logic [2:0]           state_q,    state_d;
    logic [SEL_W-1:0]     chal_q,     chal_d;
    logic [WIN_W-1:0]     win_q,      win_d;
    logic [WIN_W-1:0]     win_cnt_q,  win_cnt_d;
    logic [IDX_W-1:0]     bit_q,      bit_d;
    logic [CNT_W-1:0]     cnt_a_q,    cnt_a_d;
    logic [CNT_W-1:0]     cnt_b_q,    cnt_b_d;
    // [0] first sync stage, [1] second sync stage, [2] previous value
    logic [2:0]           sync_a_q,   sync_a_d;
    logic [2:0]           sync_b_q,   sync_b_d;
    logic [RESP_BITS-1:0] response_q, response_d;
    logic                 tie_q,      tie_d;
`ifdef PUF_MAJORITY_EN
    logic [1:0]           rep_q,      rep_d;
    logic [1:0]           votes_q,    votes_d;
    logic [1:0]           w_votes_tot;
`endif

    logic [IDX_W:0]       w_bit_x2;
    logic [SEL_W-1:0]     w_idx_a;
    logic [SEL_W-1:0]     w_idx_b;
    logic                 w_ro_a;
    logic                 w_ro_b;
    logic                 w_rise_a;
    logic                 w_rise_b;
    logic                 w_count_en;
    logic                 w_a_gt_b;
    logic                 w_a_eq_b;
    logic                 w_bit_done;
    logic                 w_pair_en;
    logic [WIN_W-1:0]     w_win_eff;

    // Pair selection: the sum wraps naturally by truncation to SEL_W bits.
    assign w_bit_x2 = {bit_q, 1'b0};
    assign w_idx_a  = chal_q + SEL_W'(w_bit_x2);
    assign w_idx_b  = w_idx_a + SEL_W'(1);

    assign w_ro_a   = ro_in[w_idx_a];
    assign w_ro_b   = ro_in[w_idx_b];
    assign w_rise_a = sync_a_q[1] & ~sync_a_q[2];
    assign w_rise_b = sync_b_q[1] & ~sync_b_q[2];

    // Counting continues through DRAIN so edges still inside the
    // synchronisers when the oscillators are gated off are not lost.
    assign w_count_en = (state_q == c_ST_COUNT) || (state_q == c_ST_DRAIN);
    assign w_a_gt_b   = (cnt_a_q > cnt_b_q);
    assign w_a_eq_b   = (cnt_a_q == cnt_b_q);
    assign w_win_eff  = (win_len == '0) ? WIN_W'(1) : win_len;

`ifdef PUF_MAJORITY_EN
    assign w_votes_tot = votes_q + {1'b0, w_a_gt_b};
    assign w_bit_done  = (rep_q == 2'd2);
`else
    assign w_bit_done  = 1'b1;
`endif

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q    <= c_ST_IDLE;
            chal_q     <= '0;
            win_q      <= '0;
            win_cnt_q  <= '0;
            bit_q      <= '0;
            cnt_a_q    <= '0;
            cnt_b_q    <= '0;
            sync_a_q   <= '0;
            sync_b_q   <= '0;
            response_q <= '0;
            tie_q      <= 1'b0;
`ifdef PUF_MAJORITY_EN
            rep_q      <= '0;
            votes_q    <= '0;
`endif
        end else begin
            state_q    <= state_d;
            chal_q     <= chal_d;
            win_q      <= win_d;
            win_cnt_q  <= win_cnt_d;
            bit_q      <= bit_d;
            cnt_a_q    <= cnt_a_d;
            cnt_b_q    <= cnt_b_d;
            sync_a_q   <= sync_a_d;
            sync_b_q   <= sync_b_d;
            response_q <= response_d;
            tie_q      <= tie_d;
`ifdef PUF_MAJORITY_EN
            rep_q      <= rep_d;
            votes_q    <= votes_d;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Next-state and datapath logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        chal_d     = chal_q;
        win_d      = win_q;
        win_cnt_d  = win_cnt_q;
        bit_d      = bit_q;
        cnt_a_d    = cnt_a_q;
        cnt_b_d    = cnt_b_q;
        response_d = response_q;
        tie_d      = tie_q;
`ifdef PUF_MAJORITY_EN
        rep_d      = rep_q;
        votes_d    = votes_q;
`endif
        sync_a_d   = {sync_a_q[1:0], w_ro_a};
        sync_b_d   = {sync_b_q[1:0], w_ro_b};

        // Saturating edge counters
        if (w_count_en) begin
            if (w_rise_a && (cnt_a_q != {CNT_W{1'b1}})) begin
                cnt_a_d = cnt_a_q + CNT_W'(1);
            end
            if (w_rise_b && (cnt_b_q != {CNT_W{1'b1}})) begin
                cnt_b_d = cnt_b_q + CNT_W'(1);
            end
        end

        case (state_q)
            c_ST_IDLE: begin
                if (start) begin
                    chal_d     = challenge;
                    win_d      = w_win_eff;
                    response_d = '0;
                    tie_d      = 1'b0;
                    bit_d      = '0;
`ifdef PUF_MAJORITY_EN
                    rep_d      = '0;
                    votes_d    = '0;
`endif
                    state_d    = c_ST_ARM;
                end
            end
            c_ST_ARM: begin
                cnt_a_d   = '0;
                cnt_b_d   = '0;
                sync_a_d  = '0;
                sync_b_d  = '0;
                win_cnt_d = '0;
                state_d   = c_ST_COUNT;
            end
            c_ST_COUNT: begin
                if (win_cnt_q == (win_q - WIN_W'(1))) begin
                    win_cnt_d = '0;
                    state_d   = c_ST_DRAIN;
                end else begin
                    win_cnt_d = win_cnt_q + WIN_W'(1);
                end
            end
            c_ST_DRAIN: begin
                if (win_cnt_q == WIN_W'(1)) begin
                    state_d = c_ST_COMPARE;
                end else begin
                    win_cnt_d = win_cnt_q + WIN_W'(1);
                end
            end
            c_ST_COMPARE: begin
                if (w_a_eq_b) begin
                    tie_d = 1'b1;
                end
`ifdef PUF_MAJORITY_EN
                if (w_bit_done) begin
                    response_d[bit_q] = (w_votes_tot >= 2'd2);
                    rep_d             = '0;
                    votes_d           = '0;
                end else begin
                    rep_d   = rep_q + 2'd1;
                    votes_d = w_votes_tot;
                end
`else
                response_d[bit_q] = w_a_gt_b;
`endif
                if (!w_bit_done) begin
                    state_d = c_ST_ARM;
                end else if (bit_q == IDX_W'(RESP_BITS - 1)) begin
                    state_d = c_ST_FINISH;
                end else begin
                    bit_d   = bit_q + IDX_W'(1);
                    state_d = c_ST_ARM;
                end
            end
            c_ST_FINISH: begin
                state_d = c_ST_IDLE;
            end
            default: begin
                state_d = c_ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        busy      = (state_q != c_ST_IDLE) && (state_q != c_ST_FINISH);
        done      = (state_q == c_ST_FINISH);
        w_pair_en = (state_q == c_ST_ARM) || (state_q == c_ST_COUNT);
    end

    // Only the two selected oscillators can ever be enabled.
    generate
        for (genvar k = 0; k < NUM_RO; k++) begin : g_ro_en
            assign ro_en[k] = w_pair_en &
                              ((w_idx_a == SEL_W'(k)) | (w_idx_b == SEL_W'(k)));
        end
    endgenerate

    assign response = response_q;
    assign tie      = tie_q;

endmodule
`default_nettype wire

// File: tb/tb_ro_puf_eval.sv
`default_nettype none
// ============================================================================
// Module   : tb_ro_puf_eval
// Purpose  : Self-checking bench for ro_puf_eval. Behavioural oscillators
//            toggle every (k+2)*2 cycles while enabled; expected counts,
//            enables, latency and responses come from an arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ro_puf_eval;

    localparam int NRO = 8;
    localparam int RB  = 4;
`ifdef PUF_MAJORITY_EN
    localparam int REPS = 3;
`else
    localparam int REPS = 1;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    always #5 clk = ~clk;

    logic        start;
    logic [2:0]  challenge;
    logic [15:0] win_len;
    logic [7:0]  ro_in;
    logic [7:0]  ro_en;
    logic        busy, done, tie;
    logic [3:0]  response;

    logic        s_start;
    logic [2:0]  s_challenge;
    logic [15:0] s_win_len;
    logic [7:0]  s_ro_in;
    logic [7:0]  s_ro_en;
    logic        s_busy, s_done, s_tie;
    logic [3:0]  s_response;

    int n_cmp  = 0;
    int n_fail = 0;

    ro_puf_eval #(.NUM_RO(NRO), .CNT_W(16), .WIN_W(16), .RESP_BITS(RB)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .challenge(challenge),
        .win_len(win_len), .ro_in(ro_in), .ro_en(ro_en), .busy(busy),
        .done(done), .response(response), .tie(tie)
    );

    ro_puf_eval #(.NUM_RO(NRO), .CNT_W(4), .WIN_W(16), .RESP_BITS(RB)) dut_sat (
        .clk(clk), .rst_n(rst_n), .start(s_start), .challenge(s_challenge),
        .win_len(s_win_len), .ro_in(s_ro_in), .ro_en(s_ro_en), .busy(s_busy),
        .done(s_done), .response(s_response), .tie(s_tie)
    );

    // Behavioural oscillators: stopped (low) while disabled.
    logic       use_common = 1'b0;
    logic       common_tog = 1'b0;
    int         common_cnt = 0;
    logic [7:0] osc_tog [2];
    int         osc_cnt [2][8];
    logic [7:0] en_v    [2];

    assign en_v[0] = ro_en;
    assign en_v[1] = s_ro_en;
    assign ro_in   = use_common ? {8{common_tog}} : osc_tog[0];
    assign s_ro_in = use_common ? {8{common_tog}} : osc_tog[1];

    initial begin
        for (int d = 0; d < 2; d++) begin
            osc_tog[d] = '0;
            for (int k = 0; k < 8; k++) osc_cnt[d][k] = 0;
        end
    end

    always @(negedge clk) begin
        if (common_cnt == 1) begin
            common_tog <= ~common_tog;
            common_cnt <= 0;
        end else begin
            common_cnt <= common_cnt + 1;
        end
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 8; k++) begin
                if (en_v[d][k]) begin
                    if (osc_cnt[d][k] + 1 == (k + 2) * 2) begin
                        osc_tog[d][k] <= ~osc_tog[d][k];
                        osc_cnt[d][k] <= 0;
                    end else begin
                        osc_cnt[d][k] <= osc_cnt[d][k] + 1;
                    end
                end else begin
                    osc_tog[d][k] <= 1'b0;
                    osc_cnt[d][k] <= 0;
                end
            end
        end
    end

    // Oscillator k produces rising edges at enable-relative cycles
    // (2m+1)*h-1 with h=(k+2)*2; all edges inside the window are counted.
    function automatic int exp_cnt(input int k, input int w, input int cw);
        int h, c, mx;
        h  = (k + 2) * 2;
        c  = (w + 1 + h) / (2 * h);
        mx = (1 << cw) - 1;
        return (c > mx) ? mx : c;
    endfunction

    // Returns {tie, response}.
    function automatic logic [RB:0] model(input int chal, input int w,
                                          input bit common, input int cw);
        logic [RB:0] r;
        int a, b, ca, cb;
        r = '0;
        for (int i = 0; i < RB; i++) begin
            a = (chal + 2 * i) % NRO;
            b = (chal + 2 * i + 1) % NRO;
            if (common) begin
                ca = 0;
                cb = 0;
            end else begin
                ca = exp_cnt(a, w, cw);
                cb = exp_cnt(b, w, cw);
            end
            r[i] = (ca > cb);
            if (ca == cb) r[RB] = 1'b1;
        end
        return r;
    endfunction

    function automatic logic [7:0] exp_en(input int chal, input int w, input int t);
        logic [7:0] m;
        int i, off, a, b;
        m = '0;
        if (t < RB * REPS * (w + 4)) begin
            i   = (t / (w + 4)) / REPS;
            off = t % (w + 4);
            if (off <= w) begin
                a = (chal + 2 * i) % NRO;
                b = (a + 1) % NRO;
                m[a] = 1'b1;
                m[b] = 1'b1;
            end
        end
        return m;
    endfunction

    task automatic run_eval(input int chal, input int wl, input bit common,
                            input bit restart_mid, input string name);
        int w, total, errs_busy, errs_en, n_done, t_done;
        logic [RB:0] exp;
        w         = (wl == 0) ? 1 : wl;
        total     = RB * REPS * (w + 4);
        exp       = model(chal, w, common, 16);
        errs_busy = 0;
        errs_en   = 0;
        n_done    = 0;
        t_done    = -1;
        @(negedge clk);
        use_common = common;
        challenge  = 3'(chal);
        win_len    = 16'(wl);
        start      = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        challenge = 3'($urandom);
        win_len   = 16'($urandom_range(0, 3));
        n_cmp++;
        if (response !== 4'b0 || tie !== 1'b0) begin
            n_fail++;
            $display("FAIL %s clear_on_start: got resp=%b tie=%b expected resp=0000 tie=0",
                     name, response, tie);
        end
        for (int t = 0; t <= total + 3; t++) begin
            if (t > 0) @(negedge clk);
            start = restart_mid && (t == w / 2 + 1);
            if (busy !== (t < total)) errs_busy++;
            if (ro_en !== exp_en(chal, w, t)) errs_en++;
            if (done === 1'b1) begin
                n_done++;
                if (t_done < 0) t_done = t;
            end
        end
        start = 1'b0;
        n_cmp++;
        if (errs_busy != 0) begin
            n_fail++;
            $display("FAIL %s busy: got %0d wrong cycles expected 0", name, errs_busy);
        end
        n_cmp++;
        if (errs_en != 0) begin
            n_fail++;
            $display("FAIL %s ro_en: got %0d wrong cycles expected 0", name, errs_en);
        end
        n_cmp++;
        if (n_done != 1) begin
            n_fail++;
            $display("FAIL %s done_count: got %0d expected 1", name, n_done);
        end
        n_cmp++;
        if (t_done + 1 != total + 1) begin
            n_fail++;
            $display("FAIL %s latency: got %0d expected %0d", name, t_done + 1, total + 1);
        end
        n_cmp++;
        if (response !== exp[RB-1:0]) begin
            n_fail++;
            $display("FAIL %s response: got %b expected %b", name, response, exp[RB-1:0]);
        end
        n_cmp++;
        if (tie !== exp[RB]) begin
            n_fail++;
            $display("FAIL %s tie: got %b expected %b", name, tie, exp[RB]);
        end
    endtask

    task automatic run_sat(input int chal, input int wl, input bit common, input string name);
        int w, limit, n_done;
        logic [RB:0] exp;
        w      = (wl == 0) ? 1 : wl;
        limit  = RB * REPS * (w + 4) + 6;
        exp    = model(chal, w, common, 4);
        n_done = 0;
        @(negedge clk);
        use_common  = common;
        s_challenge = 3'(chal);
        s_win_len   = 16'(wl);
        s_start     = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
        for (int t = 0; t < limit; t++) begin
            if (s_done === 1'b1) n_done++;
            @(negedge clk);
        end
        n_cmp++;
        if (n_done != 1) begin
            n_fail++;
            $display("FAIL %s done_count: got %0d expected 1", name, n_done);
        end
        n_cmp++;
        if (s_response !== exp[RB-1:0]) begin
            n_fail++;
            $display("FAIL %s response: got %b expected %b", name, s_response, exp[RB-1:0]);
        end
        n_cmp++;
        if (s_tie !== exp[RB]) begin
            n_fail++;
            $display("FAIL %s tie: got %b expected %b", name, s_tie, exp[RB]);
        end
    endtask

    task automatic test_reset;
        #12;
        n_cmp++;
        if ({ro_en, busy, done, response, tie} !== 15'b0) begin
            n_fail++;
            $display("FAIL reset_state: got ro_en=%h busy=%b done=%b resp=%b tie=%b expected all 0",
                     ro_en, busy, done, response, tie);
        end
        @(negedge clk);
        rst_n = 1'b0;
    endtask

    task automatic test_basic;
        run_eval(0, 100, 1'b0, 1'b0, "basic");
    endtask

    task automatic test_wrap;
        run_eval(7, 100, 1'b0, 1'b0, "wrap");
    endtask

    task automatic test_tie_saturation;
        run_sat(0, 200, 1'b1, "sat_common");
        run_sat(0, 200, 1'b0, "sat_indep");
        run_eval(3, 40, 1'b1, 1'b0, "tie_common");
    endtask

    task automatic test_start_while_busy;
        run_eval(2, 100, 1'b0, 1'b1, "start_busy");
    endtask

    task automatic test_zero_window;
        run_eval(5, 0, 1'b0, 1'b0, "zero_window");
    endtask

    task automatic test_reset_mid;
        int target, n_done;
        target = 2 * REPS * 104 + 1 + 50;
        n_done = 0;
        @(negedge clk);
        use_common = 1'b0;
        challenge  = 3'd0;
        win_len    = 16'd100;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int t = 1; t <= target; t++) @(negedge clk);
        #2 rst_n = 1'b1;
        #1;
        n_cmp++;
        if (ro_en !== 8'h00) begin
            n_fail++;
            $display("FAIL abort_ro_en: got %h expected 00", ro_en);
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_busy: got %b expected 0", busy);
        end
        n_cmp++;
        if (response !== 4'b0 || tie !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_resp_tie: got resp=%b tie=%b expected 0000/0", response, tie);
        end
        @(negedge clk);
        rst_n = 1'b0;
        for (int t = 0; t < 500; t++) begin
            if (done === 1'b1 || busy === 1'b1) n_done++;
            @(negedge clk);
        end
        n_cmp++;
        if (n_done != 0) begin
            n_fail++;
            $display("FAIL abort_no_done: got %0d active cycles expected 0", n_done);
        end
        run_eval(0, 100, 1'b0, 1'b0, "after_abort");
    endtask

    task automatic test_random;
        for (int n = 0; n < 6; n++) begin
            run_eval(int'($urandom_range(0, 7)), int'($urandom_range(0, 60)),
                     1'b0, bit'($urandom_range(0, 1)), "random");
        end
    endtask

    initial begin
        start       = 1'b0;
        challenge   = '0;
        win_len     = '0;
        s_start     = 1'b0;
        s_challenge = '0;
        s_win_len   = '0;
        test_reset;
        test_basic;
        test_wrap;
        test_tie_saturation;
        test_start_while_busy;
        test_zero_window;
        test_reset_mid;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
